// File: rtl/arith_pkg.sv
// Shared definitions for the bit-serial arithmetic path: sequencer states and op encodings.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/full_adder.sv
// One-bit full-adder slice shared by the serial arithmetic sequencer.
module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);

    logic w_axb;

    assign w_axb  = i_a ^ i_b;
    assign o_sum  = w_axb ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_cin & w_axb);

endmodule

// File: rtl/serial_addsub_seq.sv
// Bit-serial add/subtract sequencer: one full-adder slice iterated LSB first over WIDTH cycles.
// Handshakes: a transfer occurs on a rising edge where valid && ready; producers hold data stable until then.
module serial_addsub_seq
    import arith_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic             abort,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_sum,
    output logic             rsp_cout,
    output logic             rsp_ovf
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    seq_state_t       r_state;
    seq_state_t       w_next_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_res_sh;
    logic             r_carry;
    logic             r_c_msb_in;
    logic [CNT_W-1:0] r_cnt;

    logic w_sum;
    logic w_cout;
    logic w_accept;
    logic w_last;
    logic w_is_sub;

    full_adder u_slice (
        .i_a    (r_a_sh[0]),
        .i_b    (r_b_sh[0]),
        .i_cin  (r_carry),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    assign w_accept = (r_state == IDLE) && req_valid;
    assign w_last   = (r_cnt == LAST_BIT);
    assign w_is_sub = (req_op == OP_SUB);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Abort outranks the response handshake; both simply return to IDLE.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: if (req_valid) w_next_state = RUN;
            RUN: begin
                if (abort)       w_next_state = IDLE;
                else if (w_last) w_next_state = DONE;
            end
            DONE: begin
                if (abort)          w_next_state = IDLE;
                else if (rsp_ready) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Subtraction folds into addition: invert b and seed the carry with 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sh     <= '0;
            r_b_sh     <= '0;
            r_res_sh   <= '0;
            r_carry    <= 1'b0;
            r_c_msb_in <= 1'b0;
            r_cnt      <= '0;
        end else if (w_accept) begin
            r_a_sh  <= req_a;
            r_b_sh  <= req_b ^ {WIDTH{w_is_sub}};
            r_carry <= w_is_sub;
            r_cnt   <= '0;
        end else if ((r_state == RUN) && !abort) begin
            r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
            r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
            r_res_sh <= {w_sum, r_res_sh[WIDTH-1:1]};
            r_carry  <= w_cout;
            r_cnt    <= r_cnt + 1'b1;
            if (w_last) begin
                r_c_msb_in <= r_carry;
            end
        end
    end

    assign req_ready = (r_state == IDLE);
    assign rsp_valid = (r_state == DONE);
    assign rsp_sum   = r_res_sh;
    assign rsp_cout  = r_carry;
    assign rsp_ovf   = r_c_msb_in ^ r_carry;

endmodule

// File: tb/tb_serial_addsub_seq.sv
// Directed and streamed checks of the 8-bit serial add/subtract sequencer.
module tb_serial_addsub_seq;
    import arith_pkg::*;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         req_valid;
    logic         req_ready;
    logic         req_op;
    logic [W-1:0] req_a;
    logic [W-1:0] req_b;
    logic         abort;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_sum;
    logic         rsp_cout;
    logic         rsp_ovf;

    int n_checks = 0;
    int n_errors = 0;

    logic [W+1:0] exp_q[$];

    serial_addsub_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .abort     (abort),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .rsp_ovf   (rsp_ovf)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: plain integer arithmetic, returns {sum, cout, ovf}.
    function automatic logic [W+1:0] model(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0]   full;
        logic [W-1:0] s;
        logic         ovf;
        if (op == OP_SUB) full = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
        else              full = {1'b0, a} + {1'b0, b};
        s = full[W-1:0];
        if (op == OP_SUB) ovf = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
        else              ovf = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
        return {s, full[W], ovf};
    endfunction

    // ---------------- driver tasks (called at a falling edge) ----------------
    task automatic issue(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
        int waited = 0;
        while (!req_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check("issue_ready", 32'(req_ready), 32'd1);
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int max_cycles, output int lat);
        lat = 0;
        while (!rsp_valid && lat < max_cycles) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic check_no_rsp(input string name, input int cycles);
        logic saw = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (rsp_valid) saw = 1'b1;
        end
        check(name, 32'(saw), 32'd0);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic         op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int   lat;
        int   got_cnt;
        int   cyc;
        logic r;

        vecs[0] = '{OP_ADD, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
        vecs[1] = '{OP_SUB, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0};
        vecs[2] = '{OP_SUB, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1};
        vecs[3] = '{OP_ADD, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
        vecs[4] = '{OP_ADD, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0};
        vecs[5] = '{OP_SUB, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0};
        vecs[6] = '{OP_ADD, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1};
        vecs[7] = '{OP_SUB, 8'h7F, 8'hFF, 8'h80, 1'b0, 1'b1};
        vecs[8] = '{OP_ADD, 8'h55, 8'hAA, 8'hFF, 1'b0, 1'b0};

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_op    = 1'b0;
        req_a     = '0;
        req_b     = '0;
        abort     = 1'b0;
        rsp_ready = 1'b1;

        // Reset values
        @(negedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_sum",   32'(rsp_sum),   32'd0);
        check("rst_rsp_cout",  32'(rsp_cout),  32'd0);
        check("rst_rsp_ovf",   32'(rsp_ovf),   32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven vectors, rsp_ready held high
        for (int i = 0; i < 9; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_rsp(40, lat);
            check($sformatf("v%0d_latency", i), 32'(lat), 32'd8);
            check($sformatf("v%0d_sum", i),  32'(rsp_sum),  32'(vecs[i].sum));
            check($sformatf("v%0d_cout", i), 32'(rsp_cout), 32'(vecs[i].cout));
            check($sformatf("v%0d_ovf", i),  32'(rsp_ovf),  32'(vecs[i].ovf));
            @(negedge clk);
            check($sformatf("v%0d_ready_after", i), 32'(req_ready), 32'd1);
            check($sformatf("v%0d_valid_after", i), 32'(rsp_valid), 32'd0);
        end

        // Backpressure: response held while request inputs wiggle
        rsp_ready = 1'b0;
        issue(OP_ADD, 8'h3C, 8'h0F);
        wait_rsp(40, lat);
        check("bp_latency", 32'(lat), 32'd8);
        for (int i = 0; i < 5; i++) begin
            req_a     = W'($urandom_range(0, 255));
            req_b     = W'($urandom_range(0, 255));
            req_valid = 1'b1;
            @(negedge clk);
            check("bp_valid", 32'(rsp_valid), 32'd1);
            check("bp_sum",   32'(rsp_sum),   32'h4B);
            check("bp_cout",  32'(rsp_cout),  32'd0);
            check("bp_ovf",   32'(rsp_ovf),   32'd0);
            check("bp_req_ready", 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_ready_after_hs", 32'(req_ready), 32'd1);
        check("bp_valid_after_hs", 32'(rsp_valid), 32'd0);

        // Abort while bit 3 is being processed
        issue(OP_ADD, 8'h99, 8'h11);
        repeat (3) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_idle", 32'(req_ready), 32'd1);
        check("abort_valid", 32'(rsp_valid), 32'd0);
        check_no_rsp("abort_no_rsp", 12);
        issue(OP_ADD, 8'h12, 8'h34);
        wait_rsp(40, lat);
        check("post_abort_latency", 32'(lat), 32'd8);
        check("post_abort_sum", 32'(rsp_sum), 32'h46);
        @(negedge clk);

        // Asynchronous reset mid-RUN
        issue(OP_ADD, 8'hFF, 8'hFF);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_req_ready", 32'(req_ready), 32'd1);
        check("arst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("arst_rsp_sum",   32'(rsp_sum),   32'd0);
        check("arst_rsp_cout",  32'(rsp_cout),  32'd0);
        check("arst_rsp_ovf",   32'(rsp_ovf),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        check_no_rsp("arst_no_rsp", 12);

        // Randomized back-to-back stream with random backpressure
        got_cnt = 0;
        fork
            begin
                for (int n = 0; n < 200; n++) begin
                    logic         op;
                    logic [W-1:0] a;
                    logic [W-1:0] b;
                    op = 1'($urandom_range(0, 1));
                    a  = W'($urandom_range(0, 255));
                    b  = W'($urandom_range(0, 255));
                    exp_q.push_back(model(op, a, b));
                    issue(op, a, b);
                end
            end
            begin
                cyc = 0;
                while (got_cnt < 200 && cyc < 20000) begin
                    @(negedge clk);
                    cyc++;
                    r = 1'($urandom_range(0, 1));
                    rsp_ready = r;
                    if (rsp_valid && r) begin
                        if (exp_q.size() == 0) begin
                            check("stream_unexpected_rsp", 32'(rsp_valid), 32'd0);
                        end else begin
                            check($sformatf("stream_op%0d", got_cnt),
                                  32'({rsp_sum, rsp_cout, rsp_ovf}), 32'(exp_q.pop_front()));
                        end
                        got_cnt++;
                    end
                end
                check("stream_count", 32'(got_cnt), 32'd200);
            end
        join
        rsp_ready = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
